// File: rtl/h80bus_pkg.sv
// Shared h80 bus definitions: command encodings and command decode helpers.
package h80bus_pkg;

    localparam int BUS_CMD_W = 3;

    localparam logic [BUS_CMD_W-1:0] BUS_CMD_NONE    = 3'd0;
    localparam logic [BUS_CMD_W-1:0] BUS_CMD_WRITE_B = 3'd2;
    localparam logic [BUS_CMD_W-1:0] BUS_CMD_READ_B  = 3'd3;
    localparam logic [BUS_CMD_W-1:0] BUS_CMD_WRITE_W = 3'd4;
    localparam logic [BUS_CMD_W-1:0] BUS_CMD_READ_W  = 3'd5;

    // Bit 0 of every command selects direction: 1 means the responder drives data.
    function automatic logic bus_cmd_is_read(input logic [BUS_CMD_W-1:0] c);
        return c[0];
    endfunction

    function automatic logic bus_cmd_is_legal(input logic [BUS_CMD_W-1:0] c);
        logic w_legal;
        case (c)
            BUS_CMD_WRITE_B, BUS_CMD_READ_B,
            BUS_CMD_WRITE_W, BUS_CMD_READ_W: w_legal = 1'b1;
            default:                         w_legal = 1'b0;
        endcase
        return w_legal;
    endfunction

endpackage

// File: rtl/h80bus_master.sv
// h80 bus initiator: one transaction at a time, wait-state stretching with timeout,
// single-cycle response strobe. Bus outputs are registered from the next state.
module h80bus_master
    import h80bus_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  req_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [BUS_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_TURN,
        ST_ERR
    } h80bus_master_state_t;

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYCLES);
    localparam logic [BUS_DATA_WIDTH-1:0] BYTE_MASK = {{(BUS_DATA_WIDTH-8){1'b0}}, 8'hFF};

    h80bus_master_state_t      r_state;
    h80bus_master_state_t      w_next;
    logic [15:0]               r_cnt;
    logic [BUS_ADDR_WIDTH-1:0] r_addr;
    logic [BUS_CMD_WIDTH-1:0]  r_cmd;
    logic [BUS_DATA_WIDTH-1:0] r_wdata;
    logic                      r_ce_n;
    logic                      r_drive;
    logic                      r_rsp_valid;
    logic                      r_rsp_err;
    logic [BUS_DATA_WIDTH-1:0] r_rsp_rdata;

    logic                      w_req_legal;
    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_bus_next;
    logic [BUS_CMD_WIDTH-1:0]  w_cmd_next;
    logic [BUS_DATA_WIDTH-1:0] w_rd_capture;

    // Upper command bits beyond the encoded range must be zero to be legal.
    assign w_req_legal  = ((req_cmd >> BUS_CMD_W) == '0) && bus_cmd_is_legal(req_cmd[BUS_CMD_W-1:0]);
    assign w_accept     = (r_state == ST_IDLE) && req_valid && w_req_legal;
    assign w_timeout    = (r_cnt == TO_CNT);
    assign w_cmd_next   = w_accept ? req_cmd : r_cmd;
    assign w_bus_next   = (w_next == ST_ACCESS) || (w_next == ST_WAIT);
    assign w_rd_capture = (r_cmd[BUS_CMD_W-1:0] == BUS_CMD_READ_B) ? (data_ & BYTE_MASK) : data_;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = w_req_legal ? ST_ACCESS : ST_ERR;
            ST_ACCESS: w_next = ST_WAIT;
            ST_WAIT:   if (wait_n || w_timeout) w_next = ST_TURN;
            ST_TURN:   w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_cmd       <= '0;
            r_wdata     <= '0;
            r_ce_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next;
            r_ce_n      <= !w_bus_next;
            r_drive     <= w_bus_next && !bus_cmd_is_read(w_cmd_next[BUS_CMD_W-1:0]);
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_cmd   <= req_cmd;
                r_wdata <= (req_cmd[BUS_CMD_W-1:0] == BUS_CMD_WRITE_B) ? (req_wdata & BYTE_MASK) : req_wdata;
                r_cnt   <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
            // A ready responder wins over a timeout that expires in the same cycle.
            if (r_state == ST_WAIT && w_next == ST_TURN) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= !wait_n;
                r_rsp_rdata <= (wait_n && bus_cmd_is_read(r_cmd[BUS_CMD_W-1:0])) ? w_rd_capture : '0;
            end else if (w_next == ST_ERR) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign data_     = r_drive ? r_wdata : {BUS_DATA_WIDTH{1'bz}};
    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign ce_n      = r_ce_n;
    assign addr      = r_addr;
    assign cmd       = r_cmd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_h80bus_master.sv
// Bench for h80bus_master: directed and random transactions against a bus responder
// model, with a scoreboard queue drained by a monitor on every response strobe.
module tb_h80bus_master;
  import h80bus_pkg::*;

  localparam int AW = 16;
  localparam int CW = 3;
  localparam int DW = 16;
  localparam int TO = 4;
  localparam int STUCK = 1000;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [CW-1:0] req_cmd = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ce_n;
  logic [AW-1:0] addr;
  logic [CW-1:0] cmd;
  wire  [DW-1:0] data_;
  logic          wait_n;

  h80bus_master #(
    .BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_cmd(req_cmd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ce_n(ce_n), .addr(addr), .cmd(cmd), .data_(data_), .wait_n(wait_n)
  );

  // responder: stalls for stall_cfg cycles after its first sampling edge, drives reads
  logic [DW-1:0] rd_val = '0;
  int stall_cfg = 0;
  int resp_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) resp_cnt <= 0;
    else if (!ce_n) resp_cnt <= resp_cnt + 1;
    else resp_cnt <= 0;
  end
  assign wait_n = !(resp_cnt >= 1 && resp_cnt <= stall_cfg);
  assign data_ = (!ce_n && cmd[0]) ? rd_val : {DW{1'bz}};

  // scoreboard
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          err;
    logic          chk_rd;
    logic          is_rd;
    logic [DW-1:0] wdrv;
    int            lat;
    int            ce_low;
    int            tp;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the bus and response should look like for one request.
  function automatic exp_t model(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input int st, input logic [DW-1:0] rv, input int tp);
    exp_t e;
    logic legal;
    legal = (c == 3'd2) || (c == 3'd3) || (c == 3'd4) || (c == 3'd5);
    e.addr = a;
    e.is_rd = c[0];
    e.wdrv = (c == 3'd2) ? {8'h00, wd[7:0]} : wd;
    e.tp = tp;
    e.rdata = '0;
    if (!legal) begin
      e.err = 1'b1; e.chk_rd = 1'b0; e.lat = 1; e.ce_low = 0;
    end else if (st > TO) begin
      e.err = 1'b1; e.chk_rd = 1'b1; e.lat = 3 + TO; e.ce_low = TO + 2;
    end else begin
      e.err = 1'b0; e.chk_rd = c[0]; e.lat = 3 + st; e.ce_low = 2 + st;
      if (c == 3'd3) e.rdata = {8'h00, rv[7:0]};
      else if (c == 3'd5) e.rdata = rv;
    end
    return e;
  endfunction

  // driver
  task automatic issue(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int st, input logic [DW-1:0] rv, input int tp);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 200 cycles");
      return;
    end
    stall_cfg = st;
    rd_val = rv;
    req_addr = a;
    req_cmd = c;
    req_wdata = wd;
    req_valid = 1'b1;
    exp_q.push_back(model(c, a, wd, st, rv, tp));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // monitor
  int low_run = 0, last_low = 0, acc_cyc = 0, prev_acc = 0;
  logic prev_ce = 1'b1, post_rsp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      low_run = 0; prev_ce = 1'b1; post_rsp = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        if (exp_q.size() > 0 && exp_q[$].tp > 0) check("throughput", cyc - prev_acc, exp_q[$].tp);
        prev_acc = cyc; acc_cyc = cyc; low_run = 0; last_low = 0;
      end
      if (!ce_n) begin
        low_run++;
        if (exp_q.size() > 0) begin
          check("bus_addr", addr, exp_q[0].addr);
          if (exp_q[0].is_rd) check("rd_bus_data", data_, rd_val);
          else check("wr_bus_data", data_, exp_q[0].wdrv);
        end
      end else if (!prev_ce) begin
        last_low = low_run;
      end
      if (post_rsp) check("ce_n_after_rsp", ce_n, 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_rsp: got rsp_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_err", rsp_err, e.err);
          if (e.chk_rd) check("rsp_rdata", rsp_rdata, e.rdata);
          check("latency", cyc - acc_cyc, e.lat);
          check("ce_low_cycles", last_low, e.ce_low);
          check("ce_n_at_rsp", ce_n, 1);
        end
      end
      post_rsp = rsp_valid;
      prev_ce = ce_n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    logic [2:0] c;
    int r, n;
    #12;
    check("rst_ce_n", ce_n, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_addr", addr, 0);
    check("rst_cmd", cmd, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("ready_after_rst", req_ready, 1);

    issue(BUS_CMD_WRITE_B, 16'h0000, 16'h12A5, 0, 16'h0000, 0);
    issue(BUS_CMD_READ_W,  16'h0001, 16'h0000, 3, 16'hBEEF, 0);
    issue(BUS_CMD_READ_B,  16'h0002, 16'h0000, 0, 16'hFF5A, 0);
    issue(BUS_CMD_READ_W,  16'h0003, 16'h0000, STUCK, 16'h1234, 0);
    issue(BUS_CMD_WRITE_W, 16'h0004, 16'hCAFE, TO, 16'h0000, 0);
    issue(3'd7,            16'h0005, 16'h5555, 0, 16'h0000, 0);
    issue(BUS_CMD_NONE,    16'h0006, 16'h5555, 0, 16'h0000, 0);

    // reset while the access is stretched in WAIT
    issue(BUS_CMD_READ_W, 16'h00A0, 16'h0000, 3, 16'h7777, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_ce_n", ce_n, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(BUS_CMD_WRITE_W, 16'h0010, 16'hA1B2, 0, 16'h0000, 0);
    issue(BUS_CMD_WRITE_B, 16'h0011, 16'hC3D4, 0, 16'h0000, 4);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      c = 3'($urandom_range(0, 7));
      issue(c, 16'($urandom), 16'($urandom), (r < 7) ? (r % (TO + 1)) : STUCK, 16'($urandom), 0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
